// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data requesters.
// Each access is sequenced against a req/ack memory, with a timeout abort and a starvation guard.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_DBST = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_done_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_done_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          err_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM, DONE} state_t;

    localparam logic [3:0] DBST_MAX = 4'(MAX_DBST);
    // Abort fires on the last of TIMEOUT ack-less cycles, so mem_req_o is held exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [3:0] dbst_cnt;
    logic [7:0] to_cnt;
    logic       cur_dm;
    logic       aborted;
    logic       grant_if, grant_dm, ack_hit, time_out;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        ack_hit   = 1'b0;
        time_out  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req_i && !(if_req_i && dbst_cnt == DBST_MAX)) begin
                    grant_dm  = 1'b1;
                    state_nxt = GRANT_DM;
                end else if (if_req_i) begin
                    grant_if  = 1'b1;
                    state_nxt = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_DM: begin
                if (mem_ack_i) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (to_cnt == TO_LAST) begin
                    time_out  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            cur_dm      <= 1'b0;
            aborted     <= 1'b0;
            to_cnt      <= '0;
            dbst_cnt    <= '0;
        end else begin
            if (grant_if || grant_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= grant_dm & dm_we_i;
                mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
                mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
                cur_dm      <= grant_dm;
                aborted     <= 1'b0;
            end

            if (ack_hit || time_out) mem_req_o <= 1'b0;
            if (time_out)            aborted   <= 1'b1;

            if (ack_hit && !cur_dm)             if_rdata_o <= mem_rdata_i;
            if (ack_hit && cur_dm && !mem_we_o) dm_rdata_o <= mem_rdata_i;

            if ((state == GRANT_IF || state == GRANT_DM) && !mem_ack_i) to_cnt <= to_cnt + 8'd1;
            else if (state == DONE)                                    to_cnt <= '0;

            // Starvation guard: counts DM wins while IF is kept waiting.
            if (grant_if)
                dbst_cnt <= '0;
            else if (grant_dm && if_req_i && dbst_cnt != DBST_MAX)
                dbst_cnt <= dbst_cnt + 4'd1;
            else if (state == IDLE && !if_req_i)
                dbst_cnt <= '0;
        end
    end

    assign if_done_o = (state == DONE) && !cur_dm;
    assign dm_done_o = (state == DONE) && cur_dm;
    assign err_o     = (state == DONE) && aborted;
    assign stall_o   = (if_req_i | dm_req_i) & ~(if_done_o | dm_done_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a request-level reference model predicts
// grant order, data, error and completion cycle; a monitor checks each done pulse against it.
module tb_mem_port_arbiter;

    localparam int T_OUT = 8;
    localparam int MAXB  = 4;
    localparam int NOACK = 99;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0;
    logic        if_done_o, dm_done_o, err_o, stall_o;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DBST(MAXB), .TIMEOUT(T_OUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .err_o(err_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_dm;
        bit          we;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          req_cycles;
        int          done_cycle;
    } exp_t;

    exp_t exp_q[$];
    int   wait_q[$];
    int   n_checks = 0, n_err = 0;
    int   exp_txn = 0, mem_txn = 0;

    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mem_store[logic [31:0]];
    logic [31:0] ref_if_rdata = '0, ref_dm_rdata = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Request-level model: one completed access per call, reads return the latest write.
    function automatic exp_t model_txn(bit is_dm, bit we, logic [31:0] addr, logic [31:0] wdata,
                                       int w, int done_cycle);
        exp_t e;
        e.is_dm = is_dm;
        e.we    = is_dm & we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = (w >= T_OUT);
        e.req_cycles = e.err ? T_OUT : w + 1;
        e.done_cycle = done_cycle;
        if (!e.err) begin
            if (!is_dm)  ref_if_rdata = ref_read(addr);
            else if (we) ref_mem[addr] = wdata;
            else         ref_dm_rdata = ref_read(addr);
        end
        e.rdata = is_dm ? ref_dm_rdata : ref_if_rdata;
        return e;
    endfunction

    // Memory: variable latency from wait_q, random junk on rdata and stray acks while idle.
    logic [31:0] obs_addr, obs_wdata;
    logic        obs_we;
    bit          obs_stable, active = 0;
    int          obs_cycles = 0, cur_w = 0;

    always @(negedge clk) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (!rst_i || !mem_req_o) begin
            active = 0;
            if (rst_i && ($urandom % 4 == 0)) mem_ack_i = 1'b1;
        end else begin
            if (!active) begin
                active     = 1;
                cur_w      = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                obs_addr   = mem_addr_o;
                obs_we     = mem_we_o;
                obs_wdata  = mem_wdata_o;
                obs_cycles = 0;
                obs_stable = 1;
                mem_txn++;
            end else if (mem_addr_o !== obs_addr || mem_we_o !== obs_we || mem_wdata_o !== obs_wdata) begin
                obs_stable = 0;
            end
            obs_cycles++;
            if (obs_cycles == cur_w + 1) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) mem_store[mem_addr_o] = mem_wdata_o;
                else mem_rdata_i = mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o] : dflt(mem_addr_o);
            end
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_i && (if_done_o || dm_done_o)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {if_done_o, dm_done_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("done_sel", {if_done_o, dm_done_o}, e.is_dm ? 2'b01 : 2'b10);
                    check("err", err_o, e.err);
                    check(e.is_dm ? "dm_rdata" : "if_rdata", e.is_dm ? dm_rdata_o : if_rdata_o, e.rdata);
                    check("mem_addr", obs_addr, e.addr);
                    check("mem_we", obs_we, e.we);
                    if (e.we) check("mem_wdata", obs_wdata, e.wdata);
                    check("req_cycles", obs_cycles, e.req_cycles);
                    check("req_stable", obs_stable, 1);
                    check("done_cycle", cyc, e.done_cycle);
                end
            end
        end
    end

    task automatic do_single(bit is_dm, bit we, logic [31:0] addr, logic [31:0] wdata, int w,
                             bit drop_early);
        exp_t e;
        int   n = 0;
        bit   got = 0;
        @(posedge clk);
        #1;
        e = model_txn(is_dm, we, addr, wdata, w, (w >= T_OUT) ? cyc + 1 + T_OUT : cyc + 2 + w);
        exp_q.push_back(e);
        wait_q.push_back(w);
        exp_txn++;
        if (is_dm) begin
            dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        @(negedge clk);
        check("stall_pending", stall_o, 1'b1);
        if (drop_early) begin
            @(posedge clk);
            #1;
            dm_req_i = 1'b0;
        end
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (if_done_o || dm_done_o) got = 1;
        end
        if (!got) check("done_wait", 0, 1);
        else      check("stall_at_done", stall_o, 1'b0);
        @(posedge clk);
        #1;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {if_done_o, dm_done_o}, 2'b00);
    endtask

    // Both requesters held continuously; grant order predicted from the burst-limit rule.
    task automatic run_both(int n);
        logic [31:0] if_a[16], dm_a[16], dm_d[16];
        logic        dw[16];
        exp_t        e;
        int dbst = 0, ii = 0, di = 0, prev_done, w, seen = 0, budget = 0;
        for (int k = 0; k < 16; k++) begin
            if_a[k] = 32'h200 + 32'(4 * k);
            dm_a[k] = 32'h300 + 32'(4 * ($urandom % 8));
            dm_d[k] = $urandom;
            dw[k]   = 1'($urandom % 2);
        end
        @(posedge clk);
        #1;
        prev_done = cyc - 1;
        for (int k = 0; k < n; k++) begin
            w = $urandom % 4;
            if (dbst < MAXB) begin
                e = model_txn(1, dw[di], dm_a[di], dm_d[di], w, prev_done + 3 + w);
                dbst++; di++;
            end else begin
                e = model_txn(0, 0, if_a[ii], 32'h0, w, prev_done + 3 + w);
                dbst = 0; ii++;
            end
            prev_done += 3 + w;
            exp_q.push_back(e);
            wait_q.push_back(w);
            exp_txn++;
        end
        ii = 0; di = 0;
        if_req_i = 1'b1; if_addr_i = if_a[0];
        dm_req_i = 1'b1; dm_we_i = dw[0]; dm_addr_i = dm_a[0]; dm_wdata_i = dm_d[0];
        while (seen < n && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (if_done_o || dm_done_o) begin
                seen++;
                if (if_done_o) ii++;
                if (dm_done_o) di++;
                @(posedge clk);
                #1;
                if (seen == n) begin
                    if_req_i = 1'b0; dm_req_i = 1'b0;
                end else begin
                    if_addr_i = if_a[ii];
                    dm_we_i = dw[di]; dm_addr_i = dm_a[di]; dm_wdata_i = dm_d[di];
                end
            end
        end
        if (seen < n) check("both_budget", seen, n);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_dones", {if_done_o, dm_done_o, err_o}, 3'b000);
        check("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'h0);
        check("rst_mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, 65'h0);
        check("rst_stall", stall_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;

        ref_mem[32'h40]   = 32'h8C01_0004;
        mem_store[32'h40] = 32'h8C01_0004;
        do_single(0, 0, 32'h40, 32'h0, 2, 0);
        do_single(1, 0, 32'h14, 32'h0, 1, 0);
        do_single(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
        do_single(1, 0, 32'h10, 32'h0, 0, 0);
        do_single(1, 0, 32'h20, 32'h0, NOACK, 0);
        do_single(0, 0, 32'h44, 32'h0, 0, 0);
        do_single(1, 1, 32'h24, 32'h1234_5678, 1, 1);
        do_single(1, 0, 32'h24, 32'h0, 3, 0);

        run_both(12);

        for (int k = 0; k < 25; k++) begin
            a = 32'h400 + 32'(4 * ($urandom % 8));
            do_single(1'($urandom % 2), 1'($urandom % 2), a, $urandom,
                      ($urandom % 10 == 0) ? NOACK : int'($urandom % 4), 0);
        end

        // Reset while a data read is stuck waiting for ack.
        wait_q.push_back(NOACK);
        exp_txn++;
        @(posedge clk);
        #1;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h30;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req_o, 1'b0);
        check("rst_mid_done", {if_done_o, dm_done_o, err_o}, 3'b000);
        check("rst_mid_rdata", {if_rdata_o, dm_rdata_o}, 64'h0);
        ref_if_rdata = '0;
        ref_dm_rdata = '0;
        dm_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        repeat (4) @(posedge clk);
        do_single(0, 0, 32'h48, 32'h0, 1, 0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("mem_txn_count", mem_txn, exp_txn);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
